rom_port_arbiter: RTL

Shares the single SDRAM read port between the four ROM requesters in the TMNT/MIA core: 68k program ROM, tile ROM, sprite ROM and theme (uPD7759C) ROM. Each requester issues a one-cycle strobe with an address. The block queues one pending request per requester and grants them by fixed priority. It runs a level handshake toward the SDRAM controller and returns registered data to each requester. It also generates the 68k ROM-ready signal that feeds the CPU DTACK logic.

---
 rtl/rom_port_arbiter_if.sv | 11 +
 rtl/rom_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter_if.sv
// SDRAM read-port handshake shared by the ROM requesters.
// The arbiter drives the request level and address; the SDRAM controller returns ack and data.
interface rom_port_arbiter_if;
   logic        sdr_req;
   logic [24:0] sdr_addr;
   logic        sdr_ack;
   logic [31:0] sdr_dout;

   modport master (output sdr_req, output sdr_addr, input sdr_ack, input sdr_dout);
   modport slave  (input sdr_req, input sdr_addr, output sdr_ack, output sdr_dout);
endinterface

// File: rtl/rom_port_arbiter.sv
// Arbitrates the 68k, tile, sprite and theme ROM requesters onto one SDRAM read port.
// Fixed priority with one pending request per requester, registered data return and a BUSY watchdog.
module rom_port_arbiter #(
   parameter logic [24:0] M68K_BASE  = 25'h0000000,
   parameter logic [24:0] TILE_BASE  = 25'h0080000,
   parameter logic [24:0] SPR_BASE   = 25'h0180000,
   parameter logic [24:0] THEME_BASE = 25'h0380000,
   parameter int          TIMEOUT    = 255
) (
   input  logic        reset,
   input  logic        clk_sys,
   input  logic        ioctl_download,
   input  logic        m68k_req,
   input  logic [17:0] m68k_addr,
   output logic [15:0] m68k_dout,
   output logic        m68k_ready,
   input  logic        tiles_req,
   input  logic [17:0] tiles_addr,
   output logic [31:0] tiles_dout,
   input  logic        spr_req,
   input  logic [18:0] spr_addr,
   output logic [31:0] spr_dout,
   input  logic        theme_req,
   input  logic [17:0] theme_addr,
   output logic [31:0] theme_dout,
   rom_port_arbiter_if.master sdr,
   output logic        timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t            state_q, state_d;
   logic [3:0]        pend_q, pend_d;
   logic [18:0]       addr_q [4];
   logic [18:0]       addr_d [4];
   logic [1:0]        win_q, win_d;
   logic              half_q, half_d;
   logic              sdr_req_q, sdr_req_d;
   logic [24:0]       sdr_addr_q, sdr_addr_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;
   logic [15:0]       m68k_dout_q, m68k_dout_d;
   logic [31:0]       tiles_dout_q, tiles_dout_d;
   logic [31:0]       spr_dout_q, spr_dout_d;
   logic [31:0]       theme_dout_q, theme_dout_d;
   logic              m68k_ready_q, m68k_ready_d;
   logic              timeout_err_q, timeout_err_d;

   logic [3:0]        strobe;
   logic [18:0]       req_addr [4];
   logic              accept, acked, expired, done;
   logic [31:0]       rdata;
   logic [1:0]        win_sel;
   logic [24:0]       formed;

   assign strobe      = {theme_req, spr_req, tiles_req, m68k_req};
   assign req_addr[0] = {1'b0, m68k_addr};
   assign req_addr[1] = {1'b0, tiles_addr};
   assign req_addr[2] = spr_addr;
   assign req_addr[3] = {1'b0, theme_addr};

   // A download parked in IDLE flushes everything and swallows strobes.
   assign accept  = !(ioctl_download && state_q == ST_IDLE);
   // The first BUSY cycle has sdr_req still low, so an ack there is not ours.
   assign acked   = (state_q == ST_BUSY) && sdr_req_q && sdr.sdr_ack;
   assign expired = (state_q == ST_BUSY) && !acked && (wdog_q == WDOG_LAST);
   assign done    = acked || expired;
   assign rdata   = acked ? sdr.sdr_dout : 32'hFFFF_FFFF;

   for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_d[gi] = !accept                          ? 1'b0 :
                          strobe[gi]                       ? 1'b1 :
                          (done && win_q == 2'(gi))        ? 1'b0 : pend_q[gi];
      assign addr_d[gi] = (accept && strobe[gi]) ? req_addr[gi] : addr_q[gi];
   end

   always_comb begin
      win_sel = 2'd3;
      if (pend_q[2]) win_sel = 2'd2;
      if (pend_q[1]) win_sel = 2'd1;
      if (pend_q[0]) win_sel = 2'd0;
   end

   always_comb begin
      case (win_sel)
         2'd0:    formed = M68K_BASE  + {5'b0, addr_q[0], 1'b0};
         2'd1:    formed = TILE_BASE  + {4'b0, addr_q[1], 2'b00};
         2'd2:    formed = SPR_BASE   + {4'b0, addr_q[2], 2'b00};
         default: formed = THEME_BASE + {4'b0, addr_q[3], 2'b00};
      endcase
   end

   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      half_d        = half_q;
      sdr_req_d     = sdr_req_q;
      sdr_addr_d    = sdr_addr_q;
      wdog_d        = wdog_q;
      m68k_dout_d   = m68k_dout_q;
      tiles_dout_d  = tiles_dout_q;
      spr_dout_d    = spr_dout_q;
      theme_dout_d  = theme_dout_q;
      timeout_err_d = timeout_err_q;
      m68k_ready_d  = m68k_ready_q;

      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            if (!ioctl_download && |pend_q) begin
               win_d      = win_sel;
               sdr_addr_d = formed & ~25'h3;
               half_d     = formed[1];
               state_d    = ST_BUSY;
            end
         end
         default: begin
            sdr_req_d = 1'b1;
            wdog_d    = wdog_q + 1'b1;
            if (done) begin
               state_d   = ST_IDLE;
               sdr_req_d = 1'b0;
               wdog_d    = '0;
               if (expired) timeout_err_d = 1'b1;
               case (win_q)
                  2'd0:    m68k_dout_d  = half_q ? rdata[31:16] : rdata[15:0];
                  2'd1:    tiles_dout_d = rdata;
                  2'd2:    spr_dout_d   = rdata;
                  default: theme_dout_d = rdata;
               endcase
            end
         end
      endcase

      // A fresh 68k strobe outranks the completion of its previous access.
      if (!accept)
         m68k_ready_d = 1'b1;
      else if (m68k_req)
         m68k_ready_d = 1'b0;
      else if (done && win_q == 2'd0)
         m68k_ready_d = 1'b1;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pend_q        <= '0;
         addr_q        <= '{default: '0};
         win_q         <= '0;
         half_q        <= 1'b0;
         sdr_req_q     <= 1'b0;
         sdr_addr_q    <= '0;
         wdog_q        <= '0;
         m68k_dout_q   <= '0;
         tiles_dout_q  <= '0;
         spr_dout_q    <= '0;
         theme_dout_q  <= '0;
         m68k_ready_q  <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         addr_q        <= addr_d;
         win_q         <= win_d;
         half_q        <= half_d;
         sdr_req_q     <= sdr_req_d;
         sdr_addr_q    <= sdr_addr_d;
         wdog_q        <= wdog_d;
         m68k_dout_q   <= m68k_dout_d;
         tiles_dout_q  <= tiles_dout_d;
         spr_dout_q    <= spr_dout_d;
         theme_dout_q  <= theme_dout_d;
         m68k_ready_q  <= m68k_ready_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign sdr.sdr_req  = sdr_req_q;
   assign sdr.sdr_addr = sdr_addr_q;
   assign m68k_dout    = m68k_dout_q;
   assign tiles_dout   = tiles_dout_q;
   assign spr_dout     = spr_dout_q;
   assign theme_dout   = theme_dout_q;
   assign m68k_ready   = m68k_ready_q;
   assign timeout_err  = timeout_err_q;

endmodule
